wshb_arbiter: RTL and testbench

Two-master Wishbone arbiter in the system clock domain that shares the single SDRAM controller slave port. The two masters are the VGA frame reader (master 0) and a frame writer such as a pattern generator or camera capture (master 1). The VGA reader holds `cyc` permanently high, so the arbiter enforces fairness by pre-empting at transfer boundaries after a quota of acknowledged transfers. Burst integrity is preserved: a registered-feedback burst is never split.

---
 rtl/wshb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_wshb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
// rtl/wshb_arbiter.sv - two-master Wishbone arbiter with quota pre-emption and burst protection
module wshb_arbiter #(
   parameter int QUOTA = 64,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_adr,
   input  logic [31:0]   m0_dat_ms,
   input  logic [3:0]    m0_sel,
   input  logic [2:0]    m0_cti,
   input  logic [1:0]    m0_bte,
   output logic          m0_ack,
   output logic [31:0]   m0_dat_sm,
   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_adr,
   input  logic [31:0]   m1_dat_ms,
   input  logic [3:0]    m1_sel,
   input  logic [2:0]    m1_cti,
   input  logic [1:0]    m1_bte,
   output logic          m1_ack,
   output logic [31:0]   m1_dat_sm,
   output logic          s_cyc,
   output logic          s_stb,
   output logic          s_we,
   output logic [AW-1:0] s_adr,
   output logic [31:0]   s_dat_ms,
   output logic [3:0]    s_sel,
   output logic [2:0]    s_cti,
   output logic [1:0]    s_bte,
   input  logic          s_ack,
   input  logic [31:0]   s_dat_sm,
   output logic [1:0]    gnt
);

   localparam int CW = (QUOTA > 1) ? $clog2(QUOTA) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(QUOTA - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          burst_q, burst_d;

   logic       req0, req1;
   logic       cur_cyc, other_req;
   logic [2:0] cur_cti;
   logic       at_boundary;
   logic       release_grant;

   assign req0 = m0_cyc & m0_stb;
   assign req1 = m1_cyc & m1_stb;

   always_comb begin
      cur_cyc   = m0_cyc;
      cur_cti   = m0_cti;
      other_req = req1;
      if (state_q == GNT1) begin
         cur_cyc   = m1_cyc;
         cur_cti   = m1_cti;
         other_req = req0;
      end
   end

   // An ack may hand over only if it neither opens/continues a burst nor sits inside one.
   assign at_boundary = (cur_cti != 3'b010) && !(burst_q && (cur_cti != 3'b111));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_d        = last_q;
      burst_d       = burst_q;
      release_grant = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || last_q)) begin
               state_d = GNT0;
            end else if (req1) begin
               state_d = GNT1;
            end
         end
         default: begin
            if (s_ack) begin
               if ((cnt_q == CNT_MAX) && other_req && at_boundary) begin
                  release_grant = 1'b1;
               end else begin
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CW'(1);
                  end
                  if (cur_cti == 3'b010) begin
                     burst_d = 1'b1;
                  end else if (cur_cti == 3'b111) begin
                     burst_d = 1'b0;
                  end
               end
            end else if (!cur_cyc) begin
               release_grant = 1'b1;
            end
            if (release_grant) begin
               last_d  = (state_q == GNT1);
               cnt_d   = '0;
               burst_d = 1'b0;
               if (!other_req) begin
                  state_d = IDLE;
               end else if (state_q == GNT1) begin
                  state_d = GNT0;
               end else begin
                  state_d = GNT1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         burst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_ms = '0;
      s_sel    = '0;
      s_cti    = '0;
      s_bte    = '0;
      case (state_q)
         GNT0: begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_ms = m0_dat_ms;
            s_sel    = m0_sel;
            s_cti    = m0_cti;
            s_bte    = m0_bte;
         end
         GNT1: begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
            s_cti    = m1_cti;
            s_bte    = m1_bte;
         end
         default: ;
      endcase
   end

   assign gnt       = state_q;
   assign m0_ack    = s_ack & state_q[0];
   assign m1_ack    = s_ack & state_q[1];
   assign m0_dat_sm = s_dat_sm;
   assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb/tb_wshb_arbiter.sv - scoreboard bench for wshb_arbiter against a transaction-level ownership model
module tb_wshb_arbiter;

   localparam int QUOTA = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
   logic [AW-1:0] m0_adr = '0;
   logic [31:0]   m0_dat_ms = '0;
   logic [3:0]    m0_sel = '0;
   logic [2:0]    m0_cti = '0;
   logic [1:0]    m0_bte = '0;
   logic          m0_ack;
   logic [31:0]   m0_dat_sm;
   logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
   logic [AW-1:0] m1_adr = '0;
   logic [31:0]   m1_dat_ms = '0;
   logic [3:0]    m1_sel = '0;
   logic [2:0]    m1_cti = '0;
   logic [1:0]    m1_bte = '0;
   logic          m1_ack;
   logic [31:0]   m1_dat_sm;
   logic          s_cyc, s_stb, s_we;
   logic [AW-1:0] s_adr;
   logic [31:0]   s_dat_ms;
   logic [3:0]    s_sel;
   logic [2:0]    s_cti;
   logic [1:0]    s_bte;
   logic          s_ack = 1'b0;
   logic [31:0]   s_dat_sm = '0;
   logic [1:0]    gnt;

   wshb_arbiter #(.QUOTA(QUOTA), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
      .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
      .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_ack(s_ack), .s_dat_sm(s_dat_sm), .gnt(gnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    gnt;
      logic          s_cyc, s_stb, s_we;
      logic [AW-1:0] s_adr;
      logic [31:0]   s_dat_ms;
      logic [3:0]    s_sel;
      logic [2:0]    s_cti;
      logic [1:0]    s_bte;
      logic          m0_ack, m1_ack;
      logic [31:0]   m0_dat_sm, m1_dat_sm;
   } obs_t;

   obs_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc_n = 0;

   // Reference model: who owns the slave, how many acks in this tenure (unbounded), open burst.
   int owner = -1;
   int last  = 1;
   int acks  = 0;
   bit burst = 0;

   task automatic step(input bit rn,
                       input bit c0, input bit s0, input logic [2:0] t0,
                       input bit c1, input bit s1, input logic [2:0] t1,
                       input bit ack_en, output bit a0, output bit a1);
      obs_t e;
      bit c[2], s[2], req[2];
      logic [2:0] t[2];
      bit sack, boundary;
      int o, oth;
      @(negedge clk);
      c[0] = c0; s[0] = s0; t[0] = t0;
      c[1] = c1; s[1] = s1; t[1] = t1;
      req[0] = c0 & s0;
      req[1] = c1 & s1;
      if (!rn) begin
         owner = -1; last = 1; acks = 0; burst = 0;
      end
      sack = ack_en && (!rn || (owner >= 0 && c[owner] && s[owner]));
      rst_n     = rn;
      m0_cyc    = c0; m0_stb = s0; m0_cti = t0;
      m1_cyc    = c1; m1_stb = s1; m1_cti = t1;
      m0_we     = 1'($urandom); m1_we = 1'($urandom);
      m0_adr    = $urandom; m1_adr = $urandom;
      m0_dat_ms = $urandom; m1_dat_ms = $urandom;
      m0_sel    = 4'($urandom); m1_sel = 4'($urandom);
      m0_bte    = 2'($urandom); m1_bte = 2'($urandom);
      s_dat_sm  = $urandom;
      s_ack     = sack;
      e = '0;
      e.m0_dat_sm = s_dat_sm;
      e.m1_dat_sm = s_dat_sm;
      if (owner == 0) begin
         e.gnt = 2'b01;
         e.s_cyc = m0_cyc; e.s_stb = m0_stb; e.s_we = m0_we; e.s_adr = m0_adr;
         e.s_dat_ms = m0_dat_ms; e.s_sel = m0_sel; e.s_cti = m0_cti; e.s_bte = m0_bte;
         e.m0_ack = sack;
      end else if (owner == 1) begin
         e.gnt = 2'b10;
         e.s_cyc = m1_cyc; e.s_stb = m1_stb; e.s_we = m1_we; e.s_adr = m1_adr;
         e.s_dat_ms = m1_dat_ms; e.s_sel = m1_sel; e.s_cti = m1_cti; e.s_bte = m1_bte;
         e.m1_ack = sack;
      end
      a0 = e.m0_ack;
      a1 = e.m1_ack;
      sb.push_back(e);
      if (rn) begin
         if (owner < 0) begin
            if (req[0] && req[1]) owner = 1 - last;
            else if (req[0]) owner = 0;
            else if (req[1]) owner = 1;
            acks = 0; burst = 0;
         end else begin
            o = owner;
            oth = 1 - o;
            if (sack) begin
               boundary = (t[o] != 3'b010) && !(burst && t[o] != 3'b111);
               if (acks >= QUOTA - 1 && req[oth] && boundary) begin
                  last = o; owner = oth; acks = 0; burst = 0;
               end else begin
                  acks++;
                  if (t[o] == 3'b010) burst = 1;
                  else if (t[o] == 3'b111) burst = 0;
               end
            end else if (!c[o]) begin
               last = o;
               owner = req[oth] ? oth : -1;
               acks = 0; burst = 0;
            end
         end
      end
   endtask

   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         #1;
         cyc_n++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            a.gnt = gnt; a.s_cyc = s_cyc; a.s_stb = s_stb; a.s_we = s_we;
            a.s_adr = s_adr; a.s_dat_ms = s_dat_ms; a.s_sel = s_sel;
            a.s_cti = s_cti; a.s_bte = s_bte; a.m0_ack = m0_ack; a.m1_ack = m1_ack;
            a.m0_dat_sm = m0_dat_sm; a.m1_dat_sm = m1_dat_sm;
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs cycle=%0d got gnt=%b ack=%b%b s_cyc=%b vec=%h required gnt=%b ack=%b%b s_cyc=%b vec=%h",
                        cyc_n, a.gnt, a.m1_ack, a.m0_ack, a.s_cyc, a, e.gnt, e.m1_ack, e.m0_ack, e.s_cyc, e);
            end
         end
      end
   end

   initial begin
      bit a0, a1;
      bit act[2], bst[2], cc[2], ss[2], drop[2];
      int len[2], beat[2];
      logic [2:0] tt[2];
      int w;

      repeat (3) step(0, 1, 1, 3'b000, 1, 1, 3'b000, 1, a0, a1);
      repeat (8) step(1, 1, 1, 3'b000, 0, 0, 3'b000, 1, a0, a1);
      repeat (2) step(1, 0, 0, 3'b000, 0, 0, 3'b000, 0, a0, a1);

      repeat (2) step(0, 0, 0, 3'b000, 0, 0, 3'b000, 0, a0, a1);
      repeat (18) step(1, 1, 1, 3'b000, 1, 1, 3'b000, 1, a0, a1);
      repeat (2) step(1, 0, 0, 3'b000, 0, 0, 3'b000, 0, a0, a1);

      repeat (9) step(1, 1, 1, 3'b000, 0, 0, 3'b000, 1, a0, a1);
      repeat (6) step(1, 1, 1, 3'b000, 1, 1, 3'b000, 1, a0, a1);
      repeat (2) step(1, 0, 0, 3'b000, 0, 0, 3'b000, 0, a0, a1);

      beat[1] = 0;
      for (int k = 0; k < 60 && beat[1] < 8; k++) begin
         step(1, k > 0, k > 0, 3'b000, 1, 1, (beat[1] == 7) ? 3'b111 : 3'b010,
              $urandom_range(0, 3) != 0, a0, a1);
         if (a1) beat[1]++;
      end
      repeat (3) step(1, 1, 1, 3'b000, 0, 0, 3'b000, 1, a0, a1);
      repeat (2) step(1, 0, 0, 3'b000, 0, 0, 3'b000, 0, a0, a1);

      a1 = 0;
      for (int k = 0; k < 10 && !a1; k++)
         step(1, 0, 0, 3'b000, 1, 1, 3'b000, k > 1, a0, a1);
      repeat (3) step(1, 0, 0, 3'b000, 0, 0, 3'b000, 0, a0, a1);

      repeat (3) step(1, 0, 0, 3'b000, 1, 1, 3'b000, 1, a0, a1);
      repeat (2) step(0, 0, 0, 3'b000, 1, 1, 3'b000, 1, a0, a1);
      repeat (4) step(1, 1, 1, 3'b000, 1, 1, 3'b000, 1, a0, a1);

      for (int i = 0; i < 2; i++) begin
         act[i] = 0; bst[i] = 0; len[i] = 0; beat[i] = 0;
      end
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!act[i] && $urandom_range(0, 3) == 0) begin
               act[i]  = 1;
               bst[i]  = ($urandom_range(0, 2) == 0);
               len[i]  = bst[i] ? $urandom_range(2, 8) : $urandom_range(1, 6);
               beat[i] = 0;
            end
            drop[i] = act[i] && !bst[i] && ($urandom_range(0, 31) == 0);
            cc[i] = act[i] && !drop[i];
            ss[i] = cc[i] && (bst[i] || $urandom_range(0, 7) != 0);
            tt[i] = !bst[i] ? 3'b000 : (beat[i] == len[i] - 1) ? 3'b111 : 3'b010;
         end
         step($urandom_range(0, 499) != 0, cc[0], ss[0], tt[0], cc[1], ss[1], tt[1],
              $urandom_range(0, 3) != 0, a0, a1);
         if (a0) beat[0]++;
         if (a1) beat[1]++;
         for (int i = 0; i < 2; i++)
            if (drop[i] || (act[i] && beat[i] >= len[i])) act[i] = 0;
      end

      w = 0;
      while (sb.size() > 0 && w < 10) begin
         @(negedge clk);
         w++;
      end
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
